// File: rtl/cla_addsub_pipe_pkg.sv
// Shared types and constants for the pipelined carry-lookahead add/subtract unit.
// Stage registers are sized from WIDTH_DEF, so the top is built at the default width.
package cla_addsub_pipe_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int GRP       = 4;
  localparam int HALF_DEF  = WIDTH_DEF / 2;

  typedef struct packed {
    logic                valid;
    logic [HALF_DEF-1:0] lo_sum;
    logic                carry;
    logic [HALF_DEF-1:0] a_hi;
    logic [HALF_DEF-1:0] b_hi_eff;
    logic                sub;
  } s1_t;

  typedef struct packed {
    logic                 valid;
    logic [WIDTH_DEF:0]   result;
    logic                 ovf;
  } s2_t;

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// Operand/result valid-ready bundle; master drives operands and out_ready, slave is the adder.
interface cla_addsub_pipe_if #(
  parameter int WIDTH = cla_addsub_pipe_pkg::WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, ovf
  );

endinterface

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: all internal carries from generate/propagate in one level.
// Purely combinational; groups are chained through c_i/c_o.
module cla_group4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s_o = p ^ c[3:0];
  assign c_o = c[4];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage add/subtract: low half in stage 1, high half plus carry/borrow/overflow in stage 2.
// Latency 2, one result per cycle; each stage stalls only when the stage after it is full and stalled.
module cla_addsub_pipe
  import cla_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic              clk,
  input logic              rst,
  cla_addsub_pipe_if.slave bus
);

  localparam int HALF = WIDTH / 2;
  localparam int NG   = HALF / GRP;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;

  logic in_ready;
  logic s1_adv;
  logic accept;

  assign s1_adv   = !s2_q.valid || bus.out_ready;
  assign in_ready = !s1_q.valid || s1_adv;
  assign accept   = bus.in_valid && in_ready;

  // Subtraction is a + ~b + 1: invert b here and feed sub in as the carry-in.
  logic [WIDTH-1:0] b_eff;
  logic [NG:0]      lo_c;
  logic [HALF-1:0]  lo_sum;

  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign lo_c[0] = bus.sub;

  for (genvar g = 0; g < NG; g++) begin : g_lo
    cla_group4 u_grp (
      .a_i (bus.a[g*GRP +: GRP]),
      .b_i (b_eff[g*GRP +: GRP]),
      .c_i (lo_c[g]),
      .s_o (lo_sum[g*GRP +: GRP]),
      .c_o (lo_c[g+1])
    );
  end

  always_comb begin
    s1_d          = '0;
    s1_d.valid    = accept;
    s1_d.lo_sum   = lo_sum;
    s1_d.carry    = lo_c[NG];
    s1_d.a_hi     = bus.a[WIDTH-1:HALF];
    s1_d.b_hi_eff = b_eff[WIDTH-1:HALF];
    s1_d.sub      = bus.sub;
  end

  logic [NG:0]     hi_c;
  logic [HALF-1:0] hi_sum;
  logic            c_msb_in;

  assign hi_c[0] = s1_q.carry;

  for (genvar g = 0; g < NG; g++) begin : g_hi
    cla_group4 u_grp (
      .a_i (s1_q.a_hi[g*GRP +: GRP]),
      .b_i (s1_q.b_hi_eff[g*GRP +: GRP]),
      .c_i (hi_c[g]),
      .s_o (hi_sum[g*GRP +: GRP]),
      .c_o (hi_c[g+1])
    );
  end

  // Carry into the MSB recovered from its sum bit, so the groups need no extra output.
  assign c_msb_in = hi_sum[HALF-1] ^ s1_q.a_hi[HALF-1] ^ s1_q.b_hi_eff[HALF-1];

  always_comb begin
    s2_d        = '0;
    s2_d.valid  = s1_q.valid;
    s2_d.result = {hi_c[NG] ^ s1_q.sub, hi_sum, s1_q.lo_sum};
    s2_d.ovf    = c_msb_in ^ hi_c[NG];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      if (in_ready) begin
        s1_q <= s1_d;
      end
      if (s1_adv) begin
        s2_q <= s2_d;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_q.valid;
  assign bus.result    = s2_q.result;
  assign bus.ovf       = s2_q.ovf;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed and randomized checks of cla_addsub_pipe against a behavioural add/subtract model.
module tb_cla_addsub_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cla_addsub_pipe_if #(.WIDTH(16)) bus ();

  cla_addsub_pipe #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [17:0] exp_q[$];

  logic [15:0] bp_a [8] = '{16'h1234, 16'h8000, 16'hFFFF, 16'h0005, 16'h7FFF, 16'h0000, 16'hAAAA, 16'h5555};
  logic [15:0] bp_b [8] = '{16'h0101, 16'h8000, 16'hFFFF, 16'h0007, 16'hFFFF, 16'h0000, 16'h5555, 16'hAAAA};
  logic        bp_s [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {ovf, borrow/carry, 16-bit result}
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [16:0] r;
    logic        o;
    if (!s) begin
      r = {1'b0, a} + {1'b0, b};
      o = (a[15] == b[15]) && (r[15] != a[15]);
    end else begin
      r = {(a < b), 16'(a - b)};
      o = (a[15] != b[15]) && (r[15] != a[15]);
    end
    return {o, r};
  endfunction

  // One clock: drive, score the drain and the accept seen before the edge, then step to edge+1.
  task automatic tick(input logic v, input logic [15:0] ta, input logic [15:0] tbv,
                      input logic ts, input logic rdy, output logic acc);
    logic [17:0] e;
    bus.in_valid  = v;
    bus.a         = ta;
    bus.b         = tbv;
    bus.sub       = ts;
    bus.out_ready = rdy;
    #1;
    acc = v && bus.in_ready;
    if (bus.out_valid && rdy) begin
      if (exp_q.size() == 0) begin
        check("sb_spurious", 32'(bus.out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", {14'd0, bus.ovf, bus.result}, {14'd0, e});
      end
    end
    if (acc) exp_q.push_back(model(ta, tbv, ts));
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                         input logic ts, input logic [17:0] hand);
    logic acc;
    tick(1'b1, ta, tbv, ts, 1'b1, acc);
    check({tag, "_acc"}, 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
    check({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_lat2"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_val"}, {14'd0, bus.ovf, bus.result}, {14'd0, hand});
    tick(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic        acc;
    logic        v;
    logic        pend;
    logic [15:0] ra, rb;
    logic        rs;
    int          idx;
    int          nacc;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;

    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);

    run_vec("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 18'h1_0000);
    run_vec("sub_borrow", 16'h0005, 16'h0007, 1'b1, 18'h1_FFFE);
    run_vec("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 18'h2_8000);
    run_vec("sub_ovf",    16'h8000, 16'h0001, 1'b1, 18'h2_7FFF);
    run_vec("sub_wrap",   16'h0000, 16'h0001, 1'b1, 18'h1_FFFF);
    run_vec("add_plain",  16'h1234, 16'h4321, 1'b0, 18'h0_5555);
    run_vec("sub_equal",  16'h1234, 16'h1234, 1'b1, 18'h0_0000);

    // Backpressure: out_ready low for the first 5 cycles, so set 0 is held for 3.
    idx = 0;
    for (int c = 0; c < 40 && !(idx == 8 && exp_q.size() == 0); c++) begin
      if (c >= 2 && c <= 4) begin
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_hold", {14'd0, bus.ovf, bus.result}, 32'h0_1335);
      end
      v = (idx < 8);
      tick(v, v ? bp_a[idx] : 16'd0, v ? bp_b[idx] : 16'd0, v ? bp_s[idx] : 1'b0,
           (c >= 5), acc);
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    check("bp_count", 32'(idx), 32'd8);
    check("bp_drain", 32'(exp_q.size()), 32'd0);

    // Reset mid-cycle with both stages full.
    tick(1'b1, 16'h0102, 16'h0304, 1'b0, 1'b0, acc);
    tick(1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0, acc);
    bus.in_valid = 1'b0;
    check("inflight_valid", 32'(bus.out_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_ovf", 32'(bus.ovf), 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, acc);
      check("midrst_stale", 32'(bus.out_valid), 32'd0);
    end

    // Random valid/ready run; operands held until accepted.
    nacc = 0;
    pend = 1'b0;
    ra = '0;
    rb = '0;
    rs = 1'b0;
    for (int c = 0; c < 60000 && !(nacc == 10000 && exp_q.size() == 0); c++) begin
      if (!pend && nacc < 10000) begin
        ra   = 16'($urandom);
        rb   = 16'($urandom);
        rs   = 1'($urandom_range(0, 1));
        pend = 1'b1;
      end
      v = pend && ($urandom_range(0, 3) != 0);
      tick(v, ra, rb, rs, ($urandom_range(0, 3) != 0), acc);
      if (acc) begin
        nacc++;
        pend = 1'b0;
      end
    end
    check("rnd_count", 32'(nacc), 32'd10000);
    check("rnd_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cla_addsub_pipe.md
CLA_ADDSUB_PIPE -- requirements
Module: cla_addsub_pipe

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand width; must be a multiple of 8, and only 16 is verified.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: in_valid  input  1  operand set presented.
REQ-005 SHALL have port: in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port: a  input  WIDTH  minuend/addend, unsigned.
REQ-007 SHALL have port: b  input  WIDTH  subtrahend/addend, unsigned.
REQ-008 SHALL have port: sub  input  1  0 = a+b, 1 = a-b.
REQ-009 SHALL have port: out_valid  output  1  result presented.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result this cycle.
REQ-011 SHALL have port: result  output  WIDTH+1  add: {carry, sum}; sub: {borrow, difference}.
REQ-012 SHALL have port: ovf  output  1  signed (two's-complement) overflow of the WIDTH-bit operation.

Function
REQ-013 SHALL accept an operand set on any clk edge where in_valid and in_ready are both 1; it SHALL not change a/b/sub sampling on any other edge.
REQ-014 SHALL compute subtraction as a + ~b + 1. Bit WIDTH of result SHALL be the inverted carry-out, so borrow = 1 iff a < b unsigned.
REQ-015 SHALL be a 2-stage pipeline. Stage 1 adds the low WIDTH/2 bits with 4-bit carry-lookahead groups and registers the group carry, the low sum, and the upper operand halves. Stage 2 adds the upper halves using the registered carry.
REQ-016 SHALL have a latency of exactly 2 cycles from acceptance to out_valid with no backpressure, and a throughput of 1 result per cycle.
REQ-017 Each stage valid SHALL advance when the next stage is empty or advancing; in_ready = !s1_valid || s1_advance; s1_advance = !s2_valid || out_ready.
REQ-018 result, ovf and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-019 Ordering SHALL be preserved; no operand set is dropped or duplicated under any in_valid/out_ready pattern.
REQ-020 On a simultaneous accept at input and drain at output with both stages full, the pipeline SHALL shift by one and the occupancy SHALL remain 2.
REQ-021 ovf SHALL be carry into the MSB XOR carry out of the MSB, computed on the internal post-inversion operands.
REQ-022 Wrap-around SHALL not saturate: 0xFFFF+0x0001 yields 0x1_0000, and 0x0000-0x0001 yields 0x1_FFFF.
REQ-023 There SHALL be no combinational path from a/b/sub to result; in_ready MAY depend combinationally on out_ready.

Reset
REQ-024 While rst=1, s1_valid, s2_valid and out_valid SHALL be 0, regardless of clk.
REQ-025 While rst=1, result and ovf SHALL be 0.
REQ-026 Reset during operation SHALL discard all in-flight operand sets; none SHALL emerge after reset release.
REQ-027 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-028 The shared package SHALL hold the WIDTH default, the group size constant (4), and the stage-register struct {valid, lo_sum, carry, a_hi, b_hi_eff, sub}.
REQ-029 The 4-bit generate/propagate lookahead group SHALL be a sub-module named cla_group4, instantiated WIDTH/4 times across the stages.

Verification
REQ-030 Bench SHALL cover: a=0xFFFF, b=0x0001, sub=0 -> result=0x1_0000, ovf=0, out_valid exactly 2 cycles after accept.
REQ-031 Bench SHALL cover: a=0x0005, b=0x0007, sub=1 -> result=0x1_FFFE (borrow=1), ovf=0.
REQ-032 Bench SHALL cover: a=0x7FFF, b=0x0001, sub=0 -> result=0x0_8000, ovf=1; and a=0x8000, b=0x0001, sub=1 -> result=0x0_7FFF, ovf=1.
REQ-033 Bench SHALL cover: back-to-back stream of 8 sets with out_ready held 0 for 3 cycles -> in_ready=0 once 2 sets are in flight, the held result is stable, and all 8 results arrive in order.
REQ-034 Bench SHALL cover: rst pulsed mid-cycle with 2 sets in flight -> out_valid drops immediately, and no stale result appears after release.
REQ-035 Bench SHALL cover: a randomized 10,000-transaction run with random valid/ready against a behavioural reference {a+b} / {a<b, a-b} -> zero mismatches.
